branch_target_buffer: RTL and testbench

Direct-mapped branch target buffer with 2-bit saturating direction counters, instanced as iBTB in the fetch stage of the CPU. It predicts the next fetch PC combinationally from the current fetch PC. It is trained by resolved branches from the execute stage, and it generates the mispredict and redirect signals the pipeline uses to flush. The top-level SW[0] switch drives `en`, so the same bitstream runs with prediction on or off.

---
 rtl/branch_target_buffer_if.sv | 39 +++
 rtl/branch_target_buffer.sv | 141 ++++++++++++++
 tb/tb_branch_target_buffer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/branch_target_buffer_if.sv
// Fetch/execute-side signal bundle for the branch target buffer.
// The pipeline drives through master; the BTB itself connects through slave.
interface branch_target_buffer_if #(
   parameter int ADDR_W = 16
);
   logic              en;
   logic              if_valid;
   logic [ADDR_W-1:0] if_pc;
   logic              pred_hit;
   logic              pred_taken;
   logic [ADDR_W-1:0] next_pc;
   logic              ex_valid;
   logic [ADDR_W-1:0] ex_pc;
   logic              ex_is_branch;
   logic              ex_taken;
   logic [ADDR_W-1:0] ex_target;
   logic              ex_pred_taken;
   logic [ADDR_W-1:0] ex_pred_target;
   logic              mispredict;
   logic [ADDR_W-1:0] redirect_pc;
   logic [15:0]       lookup_hits;
   logic [15:0]       mispredicts;

   modport master (
      output en, if_valid, if_pc,
      output ex_valid, ex_pc, ex_is_branch, ex_taken, ex_target,
      output ex_pred_taken, ex_pred_target,
      input  pred_hit, pred_taken, next_pc,
      input  mispredict, redirect_pc, lookup_hits, mispredicts
   );

   modport slave (
      input  en, if_valid, if_pc,
      input  ex_valid, ex_pc, ex_is_branch, ex_taken, ex_target,
      input  ex_pred_taken, ex_pred_target,
      output pred_hit, pred_taken, next_pc,
      output mispredict, redirect_pc, lookup_hits, mispredicts
   );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit saturating direction counters: combinational
// next-PC prediction at fetch, training and flush generation from execute.
module branch_target_buffer #(
   parameter int ADDR_W = 16,
   parameter int IDX_W  = 4
) (
   input logic                  clk,
   input logic                  rst,
   branch_target_buffer_if.slave bus
);
   localparam int ENTRIES = 1 << IDX_W;
   localparam int TAG_W   = ADDR_W - IDX_W;
   localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [ENTRIES-1:0] valid_q;
   logic [1:0]         ctr_q    [ENTRIES];
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [ADDR_W-1:0]  target_q [ENTRIES];
   logic [15:0]        hits_q;
   logic [15:0]        misp_q;

   logic [IDX_W-1:0]   ifIdx;
   logic [TAG_W-1:0]   ifTag;
   logic [ADDR_W-1:0]  ifPcPlus1;
   logic               predHit;
   logic               predTaken;

   logic [IDX_W-1:0]   exIdx;
   logic [TAG_W-1:0]   exTag;
   logic [ADDR_W-1:0]  exPcPlus1;
   logic               exHit;
   logic               mispredict;
   logic [ADDR_W-1:0]  redirectPc;

   logic               wrEn;
   logic               valid_d;
   logic [1:0]         ctr_d;
   logic [TAG_W-1:0]   tag_d;
   logic [ADDR_W-1:0]  target_d;

   // Fetch-side lookup: purely combinational off the current table state.
   assign ifIdx     = bus.if_pc[IDX_W-1:0];
   assign ifTag     = bus.if_pc[ADDR_W-1:IDX_W];
   assign ifPcPlus1 = bus.if_pc + PC_ONE;
   assign predHit   = bus.en & bus.if_valid & valid_q[ifIdx] & (tag_q[ifIdx] == ifTag);
   assign predTaken = predHit & ctr_q[ifIdx][1];

   assign bus.pred_hit   = predHit;
   assign bus.pred_taken = predTaken;
   assign bus.next_pc    = predTaken ? target_q[ifIdx] : ifPcPlus1;

   assign exIdx     = bus.ex_pc[IDX_W-1:0];
   assign exTag     = bus.ex_pc[ADDR_W-1:IDX_W];
   assign exPcPlus1 = bus.ex_pc + PC_ONE;
   assign exHit     = valid_q[exIdx] & (tag_q[exIdx] == exTag);

   // Flush generation deliberately ignores en so a disabled predictor still
   // recovers from the fall-through guesses the pipeline carried down.
   always_comb begin
      mispredict = 1'b0;
      redirectPc = exPcPlus1;
      if (bus.ex_valid && bus.ex_is_branch) begin
         mispredict = (bus.ex_taken != bus.ex_pred_taken) ||
                      (bus.ex_taken && (bus.ex_target != bus.ex_pred_target));
         redirectPc = bus.ex_taken ? bus.ex_target : exPcPlus1;
      end else if (bus.ex_valid && bus.ex_pred_taken) begin
         mispredict = 1'b1;
      end
   end

   assign bus.mispredict  = mispredict;
   assign bus.redirect_pc = redirectPc;

   // Next-state of the single entry addressed by the execute-stage PC.
   always_comb begin
      wrEn     = 1'b0;
      valid_d  = valid_q[exIdx];
      ctr_d    = ctr_q[exIdx];
      tag_d    = tag_q[exIdx];
      target_d = target_q[exIdx];
      if (bus.en && bus.ex_valid) begin
         if (bus.ex_is_branch) begin
            if (exHit) begin
               wrEn = 1'b1;
               if (bus.ex_taken) begin
                  ctr_d    = (ctr_q[exIdx] == 2'b11) ? 2'b11 : ctr_q[exIdx] + 2'b01;
                  target_d = bus.ex_target;
               end else begin
                  ctr_d = (ctr_q[exIdx] == 2'b00) ? 2'b00 : ctr_q[exIdx] - 2'b01;
               end
            end else if (bus.ex_taken) begin
               wrEn     = 1'b1;
               valid_d  = 1'b1;
               tag_d    = exTag;
               target_d = bus.ex_target;
               ctr_d    = 2'b10;
            end
         end else if (exHit) begin
            wrEn    = 1'b1;
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            ctr_q[i] <= 2'b00;
         end
      end else if (wrEn) begin
         valid_q[exIdx] <= valid_d;
         ctr_q[exIdx]   <= ctr_d;
      end
   end

   // Tags and targets need no reset; a cleared valid bit masks them.
   always_ff @(posedge clk) begin
      if (!rst && wrEn) begin
         tag_q[exIdx]    <= tag_d;
         target_q[exIdx] <= target_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hits_q <= '0;
         misp_q <= '0;
      end else if (bus.en) begin
         if (predHit && (hits_q != 16'hFFFF)) begin
            hits_q <= hits_q + 16'd1;
         end
         if (mispredict && (misp_q != 16'hFFFF)) begin
            misp_q <= misp_q + 16'd1;
         end
      end
   end

   assign bus.lookup_hits = hits_q;
   assign bus.mispredicts = misp_q;
endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed-vector bench for branch_target_buffer: lookup, training,
// hysteresis, alias eviction, enable gating, reset and saturation.
module tb_branch_target_buffer;
   logic clk;
   logic rst;
   int   assertCount;
   int   failCount;

   branch_target_buffer_if #(.ADDR_W(16)) bus ();

   branch_target_buffer #(.ADDR_W(16), .IDX_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Free-running clock; inputs change #1 after each rising edge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setLookup(input logic valid, input logic [15:0] pc);
      bus.if_valid = valid;
      bus.if_pc    = pc;
      #1;
   endtask

   // Drives one execute-stage slot; the comb outputs are settled on return.
   task automatic applyStimulus(input logic valid, input logic isBranch,
                                input logic taken, input logic [15:0] pc,
                                input logic [15:0] target, input logic predTaken,
                                input logic [15:0] predTarget);
      bus.ex_valid       = valid;
      bus.ex_is_branch   = isBranch;
      bus.ex_taken       = taken;
      bus.ex_pc          = pc;
      bus.ex_target      = target;
      bus.ex_pred_taken  = predTaken;
      bus.ex_pred_target = predTarget;
      #1;
   endtask

   task automatic clearEx();
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;
      rst         = 1'b1;
      bus.en      = 1'b1;
      setLookup(1'b0, 16'h0000);
      clearEx();
      tick();
      rst = 1'b0;

      // Reset state
      setLookup(1'b1, 16'h0010);
      checkOutput("rst_hit", bus.pred_hit, 1'b0);
      checkOutput("rst_taken", bus.pred_taken, 1'b0);
      checkOutput("rst_next", bus.next_pc, 16'h0011);
      checkOutput("rst_hits", bus.lookup_hits, 16'h0000);
      checkOutput("rst_misp", bus.mispredicts, 16'h0000);
      setLookup(1'b0, 16'h0010);

      // Allocate 0x0023 -> 0x0040 and predict it next cycle
      applyStimulus(1'b1, 1'b1, 1'b1, 16'h0023, 16'h0040, 1'b0, 16'h0024);
      checkOutput("alloc_misp", bus.mispredict, 1'b1);
      checkOutput("alloc_redir", bus.redirect_pc, 16'h0040);
      tick();
      clearEx();
      checkOutput("alloc_mcnt", bus.mispredicts, 16'd1);
      setLookup(1'b1, 16'h0023);
      checkOutput("alloc_hit", bus.pred_hit, 1'b1);
      checkOutput("alloc_taken", bus.pred_taken, 1'b1);
      checkOutput("alloc_next", bus.next_pc, 16'h0040);
      tick();
      setLookup(1'b0, 16'h0023);
      checkOutput("hits_one", bus.lookup_hits, 16'd1);

      // Hysteresis: 2 -> 1 (not taken) -> 2 -> 3 -> 3 (sat) -> 2
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0023, 16'h0040, 1'b1, 16'h0040);
      checkOutput("nt_misp", bus.mispredict, 1'b1);
      checkOutput("nt_redir", bus.redirect_pc, 16'h0024);
      tick();
      clearEx();
      setLookup(1'b1, 16'h0023);
      checkOutput("ctr1_hit", bus.pred_hit, 1'b1);
      checkOutput("ctr1_taken", bus.pred_taken, 1'b0);
      checkOutput("ctr1_next", bus.next_pc, 16'h0024);
      setLookup(1'b0, 16'h0023);
      applyStimulus(1'b1, 1'b1, 1'b1, 16'h0023, 16'h0040, 1'b0, 16'h0024);
      tick();
      applyStimulus(1'b1, 1'b1, 1'b1, 16'h0023, 16'h0040, 1'b1, 16'h0040);
      checkOutput("good_pred_misp", bus.mispredict, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b1, 1'b1, 16'h0023, 16'h0040, 1'b1, 16'h0040);
      tick();
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0023, 16'h0040, 1'b1, 16'h0040);
      tick();
      clearEx();
      setLookup(1'b1, 16'h0023);
      checkOutput("ctr_sat_taken", bus.pred_taken, 1'b1);
      setLookup(1'b0, 16'h0023);
      checkOutput("hyst_mcnt", bus.mispredicts, 16'd4);

      // Wrong target on a correctly-predicted direction
      applyStimulus(1'b1, 1'b1, 1'b1, 16'h0023, 16'h0050, 1'b1, 16'h0040);
      checkOutput("tgt_misp", bus.mispredict, 1'b1);
      checkOutput("tgt_redir", bus.redirect_pc, 16'h0050);
      tick();
      clearEx();
      setLookup(1'b1, 16'h0023);
      checkOutput("tgt_next", bus.next_pc, 16'h0050);

      // Alias: same index, different tag, then non-branch eviction
      setLookup(1'b1, 16'h0133);
      checkOutput("alias_hit", bus.pred_hit, 1'b0);
      checkOutput("alias_next", bus.next_pc, 16'h0134);
      setLookup(1'b0, 16'h0133);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0023, 16'h0000, 1'b1, 16'h0050);
      checkOutput("nb_misp", bus.mispredict, 1'b1);
      checkOutput("nb_redir", bus.redirect_pc, 16'h0024);
      tick();
      clearEx();
      setLookup(1'b1, 16'h0023);
      checkOutput("evict_hit", bus.pred_hit, 1'b0);
      setLookup(1'b0, 16'h0023);
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0133, 16'h0000, 1'b0, 16'h0134);
      checkOutput("nt_miss_misp", bus.mispredict, 1'b0);
      tick();
      clearEx();
      setLookup(1'b1, 16'h0133);
      checkOutput("nt_miss_noalloc", bus.pred_hit, 1'b0);
      setLookup(1'b0, 16'h0133);
      checkOutput("alias_mcnt", bus.mispredicts, 16'd6);

      // Enable off: lookups suppressed, flushes still produced, nothing written
      applyStimulus(1'b1, 1'b1, 1'b1, 16'h0023, 16'h0040, 1'b0, 16'h0024);
      tick();
      clearEx();
      bus.en = 1'b0;
      setLookup(1'b1, 16'h0023);
      checkOutput("dis_hit", bus.pred_hit, 1'b0);
      checkOutput("dis_next", bus.next_pc, 16'h0024);
      applyStimulus(1'b1, 1'b1, 1'b1, 16'h0030, 16'h0077, 1'b0, 16'h0031);
      checkOutput("dis_misp", bus.mispredict, 1'b1);
      checkOutput("dis_redir", bus.redirect_pc, 16'h0077);
      applyStimulus(1'b1, 1'b1, 1'b0, 16'h0023, 16'h0040, 1'b1, 16'h0040);
      for (int i = 0; i < 10; i++) tick();
      clearEx();
      setLookup(1'b0, 16'h0023);
      bus.en = 1'b1;
      #1;
      checkOutput("dis_mcnt", bus.mispredicts, 16'd7);
      checkOutput("dis_hcnt", bus.lookup_hits, 16'd1);
      setLookup(1'b1, 16'h0023);
      checkOutput("reen_taken", bus.pred_taken, 1'b1);
      checkOutput("reen_next", bus.next_pc, 16'h0040);
      setLookup(1'b0, 16'h0023);

      // Reset in the same cycle as an allocate
      applyStimulus(1'b1, 1'b1, 1'b1, 16'h0045, 16'h0099, 1'b0, 16'h0046);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      clearEx();
      setLookup(1'b1, 16'h0045);
      checkOutput("rst_alloc_hit", bus.pred_hit, 1'b0);
      setLookup(1'b1, 16'h0023);
      checkOutput("rst_clear_hit", bus.pred_hit, 1'b0);
      checkOutput("rst2_misp", bus.mispredicts, 16'd0);
      checkOutput("rst2_hits", bus.lookup_hits, 16'd0);

      // PC wrap at the top of the address space
      setLookup(1'b1, 16'hFFFF);
      checkOutput("wrap_next", bus.next_pc, 16'h0000);
      setLookup(1'b0, 16'hFFFF);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h1234);
      checkOutput("wrap_redir", bus.redirect_pc, 16'h0000);
      clearEx();

      // Both counters saturate at 0xFFFF
      applyStimulus(1'b1, 1'b1, 1'b1, 16'h0023, 16'h0040, 1'b0, 16'h0024);
      tick();
      setLookup(1'b1, 16'h0023);
      applyStimulus(1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, 1'b1, 16'h0200);
      for (int i = 0; i < 65540; i++) tick();
      checkOutput("sat_misp", bus.mispredicts, 16'hFFFF);
      checkOutput("sat_hits", bus.lookup_hits, 16'hFFFF);
      clearEx();
      setLookup(1'b0, 16'h0023);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end
endmodule
